psram_user_resp: RTL and testbench

- Synthesizable responder for the PSRAM controller user-side command interface: the slave end of the psram_exe / rw_ctrl / burst handshake.
- Sits in place of the real PSRAM controller so traffic initiators can run standalone in simulation and on-board smoke tests.
- Backs each command with an internal word memory.
- Issues write-data strobes, read-data beats, a calibration-done flag and the psram_done ready/complete level.

---
 rtl/psram_user_resp.sv | 193 +++++++++++++++++++
 tb/tb_psram_user_resp.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/psram_user_resp.sv
// psram_user_resp: synthesizable stand-in for the PSRAM controller user port, backed by a word memory.
// Define PSRAM_RESP_STAT_EN to add burst counters and a dropped-command flag.
//
// state  | meaning
// INIT   | emulated calibration countdown after reset
// IDLE   | psram_done high, waiting for psram_exe
// LAT    | access latency before the first beat
// WBURST | psram_wr_valid high, one word written per cycle
// RBURST | psram_rd_valid high, one word returned per cycle
// FIN    | one quiet cycle before returning to IDLE
module psram_user_resp #(
  parameter int ADDR_W      = 8,
  parameter int INIT_CYCLES = 16,
  parameter int LATENCY     = 4,
  parameter int WRAP_BITS   = 5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        init_cable_complete,
  input  logic        psram_exe,
  input  logic        rw_ctrl,
  input  logic        bit_ctrl,
  input  logic [1:0]  byte_write,
  input  logic        wrap_in,
  input  logic [31:0] addr_in,
  input  logic [15:0] data_in,
  input  logic [11:0] burst_len,
  input  logic [1:0]  command_in,
  output logic        psram_wr_valid,
  output logic        psram_rd_valid,
  output logic [15:0] data_out,
  output logic        psram_done
`ifdef PSRAM_RESP_STAT_EN
  ,
  output logic [15:0] wr_burst_cnt,
  output logic [15:0] rd_burst_cnt,
  output logic        cmd_drop
`endif
);

  typedef enum logic [2:0] {INIT, IDLE, LAT, WBURST, RBURST, FIN} state_t;

  localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'((1 << WRAP_BITS) - 1);

  state_t            state_q;
  logic [11:0]       cnt_q;
  logic              init_done_q, done_q, wr_valid_q, rd_valid_q;
  logic [15:0]       data_out_q;
  logic              rw_q, bit_q, wrap_q, zero_q;
  logic [1:0]        be_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       len_q;
  logic [15:0]       mem_q [2**ADDR_W];
  logic [15:0]       rd_word;
  logic              zero_cmd;
  logic              unused_addr;

  assign unused_addr = ^addr_in[31:ADDR_W];
  assign zero_cmd    = (command_in != 2'b00) || (burst_len == 12'd0);

  always_comb begin
    addr_d = '0;
    if (wrap_q) addr_d = addr_q + 1'b1;
    else        addr_d = (addr_q & ~WRAP_MASK) | ((addr_q + 1'b1) & WRAP_MASK);
    rd_word = bit_q ? mem_q[addr_q] : {8'h00, mem_q[addr_q][7:0]};
  end

  // byte_write bits are masks: a set bit protects that byte
  always_ff @(posedge sys_clk) begin
    if (state_q == WBURST) begin
      if (!be_q[0])         mem_q[addr_q][7:0]  <= data_in[7:0];
      if (bit_q && !be_q[1]) mem_q[addr_q][15:8] <= data_in[15:8];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q     <= INIT;
      cnt_q       <= 12'(INIT_CYCLES - 1);
      init_done_q <= 1'b0;
      done_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      data_out_q  <= 16'h0000;
      rw_q        <= 1'b0;
      bit_q       <= 1'b0;
      wrap_q      <= 1'b0;
      zero_q      <= 1'b0;
      be_q        <= 2'b00;
      addr_q      <= '0;
      len_q       <= 12'd0;
    end else begin
      case (state_q)
        INIT: begin
          if (cnt_q == 12'd0) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 12'd1;
          end
        end
        IDLE: begin
          if (psram_exe) begin
            rw_q    <= rw_ctrl;
            bit_q   <= bit_ctrl;
            be_q    <= byte_write;
            wrap_q  <= wrap_in;
            addr_q  <= addr_in[ADDR_W-1:0];
            len_q   <= burst_len;
            zero_q  <= zero_cmd;
            done_q  <= 1'b0;
            // a beatless command spends the first-beat slot in LAT
            cnt_q   <= zero_cmd ? 12'(LATENCY) : 12'(LATENCY - 1);
            state_q <= LAT;
          end
        end
        LAT: begin
          if (cnt_q != 12'd0) begin
            cnt_q <= cnt_q - 12'd1;
          end else if (zero_q) begin
            state_q <= FIN;
          end else begin
            cnt_q <= len_q;
            if (rw_q) begin
              wr_valid_q <= 1'b1;
              state_q    <= WBURST;
            end else begin
              rd_valid_q <= 1'b1;
              data_out_q <= rd_word;
              addr_q     <= addr_d;
              state_q    <= RBURST;
            end
          end
        end
        WBURST: begin
          addr_q <= addr_d;
          if (cnt_q == 12'd1) begin
            wr_valid_q <= 1'b0;
            state_q    <= FIN;
          end else begin
            cnt_q <= cnt_q - 12'd1;
          end
        end
        RBURST: begin
          if (cnt_q == 12'd1) begin
            rd_valid_q <= 1'b0;
            state_q    <= FIN;
          end else begin
            data_out_q <= rd_word;
            addr_q     <= addr_d;
            cnt_q      <= cnt_q - 12'd1;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign init_cable_complete = init_done_q;
  assign psram_done          = done_q;
  assign psram_wr_valid      = wr_valid_q;
  assign psram_rd_valid      = rd_valid_q;
  assign data_out            = data_out_q;

`ifdef PSRAM_RESP_STAT_EN
  logic [15:0] wr_cnt_q, rd_cnt_q;
  logic        drop_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_cnt_q <= 16'h0000;
      rd_cnt_q <= 16'h0000;
      drop_q   <= 1'b0;
    end else begin
      if (state_q == FIN && !zero_q) begin
        if (rw_q) wr_cnt_q <= wr_cnt_q + 16'd1;
        else      rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (psram_exe && !done_q && state_q != INIT) drop_q <= 1'b1;
    end
  end

  assign wr_burst_cnt = wr_cnt_q;
  assign rd_burst_cnt = rd_cnt_q;
  assign cmd_drop     = drop_q;
`endif

endmodule

// File: tb/tb_psram_user_resp.sv
// Directed bench for psram_user_resp with default parameters (INIT 16, LATENCY 4, wrap window 32).
module tb_psram_user_resp;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        init_cable_complete;
  logic        psram_exe = 1'b0;
  logic        rw_ctrl = 1'b0;
  logic        bit_ctrl = 1'b0;
  logic [1:0]  byte_write = 2'b00;
  logic        wrap_in = 1'b0;
  logic [31:0] addr_in = 32'h0;
  logic [15:0] data_in = 16'h0;
  logic [11:0] burst_len = 12'd0;
  logic [1:0]  command_in = 2'b00;
  logic        psram_wr_valid, psram_rd_valid, psram_done;
  logic [15:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] wbuf [64];
  logic [15:0] rbuf [64];
  logic [15:0] exp_v [64];
  int first_k, last_k, done_k, nbeats;
  int rst_beat = -1;
  bit aborted;

  always #5 sys_clk = ~sys_clk;

  psram_user_resp dut (
    .sys_clk             (sys_clk),
    .sys_rst             (sys_rst),
    .init_cable_complete (init_cable_complete),
    .psram_exe           (psram_exe),
    .rw_ctrl             (rw_ctrl),
    .bit_ctrl            (bit_ctrl),
    .byte_write          (byte_write),
    .wrap_in             (wrap_in),
    .addr_in             (addr_in),
    .data_in             (data_in),
    .burst_len           (burst_len),
    .command_in          (command_in),
    .psram_wr_valid      (psram_wr_valid),
    .psram_rd_valid      (psram_rd_valid),
    .data_out            (data_out),
    .psram_done          (psram_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic release_and_check_init();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge sys_clk);
      if (i == 1 || i == 15) begin
        check_val($sformatf("init_low_c%0d", i), init_cable_complete, 0);
        check_val($sformatf("done_low_c%0d", i), psram_done, 0);
        check_val($sformatf("no_valid_c%0d", i), {psram_wr_valid, psram_rd_valid}, 0);
      end
      if (i == 16) begin
        check_val("init_high_c16", init_cable_complete, 1);
        check_val("done_high_c16", psram_done, 1);
      end
    end
  endtask

  // k counts negedges after the accepting edge; cycle k corresponds to T+k
  task automatic run_cmd(input logic rw, input logic bc, input logic [1:0] be, input logic wi,
                         input logic [31:0] a, input logic [11:0] len, input logic [1:0] cmd,
                         input int hold);
    int k;
    for (int w = 0; w < 200 && !psram_done; w++) @(negedge sys_clk);
    check_val("ready_before_cmd", psram_done, 1);
    rw_ctrl = rw; bit_ctrl = bc; byte_write = be; wrap_in = wi;
    addr_in = a; burst_len = len; command_in = cmd; psram_exe = 1'b1;
    first_k = -1; last_k = -1; done_k = -1; nbeats = 0; aborted = 0; k = 0;
    while (done_k < 0 && !aborted && k < 6000) begin
      @(negedge sys_clk);
      k++;
      if (k > hold) psram_exe = 1'b0;
      if (psram_wr_valid || psram_rd_valid) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        if (psram_wr_valid) data_in = wbuf[nbeats % 64];
        if (psram_rd_valid && nbeats < 64) rbuf[nbeats] = data_out;
        nbeats++;
      end
      if (psram_done) done_k = k;
      if (rst_beat > 0 && psram_wr_valid && nbeats == rst_beat) begin
        sys_rst = 1'b0;
        #1;
        check_val("rst_wr_valid", psram_wr_valid, 0);
        check_val("rst_init", init_cable_complete, 0);
        check_val("rst_done", psram_done, 0);
        aborted = 1;
      end
    end
    psram_exe = 1'b0;
    data_in = 16'h0;
    check_val("cmd_completes", (done_k >= 0 || aborted), 1);
  endtask

  task automatic check_read(input string tag, input int n);
    for (int i = 0; i < n; i++)
      check_val($sformatf("%s[%0d]", tag, i), rbuf[i], exp_v[i]);
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    check_val("rst_init_cable", init_cable_complete, 0);
    check_val("rst_psram_done", psram_done, 0);
    check_val("rst_wr_valid0", psram_wr_valid, 0);
    check_val("rst_rd_valid0", psram_rd_valid, 0);
    check_val("rst_data_out", data_out, 16'h0000);
    release_and_check_init();

    // 32-beat write, wrap mode, data = beat number
    for (int i = 0; i < 64; i++) wbuf[i] = 16'(i);
    run_cmd(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 12'd32, 2'b00, 0);
    check_val("wr32_first", first_k, 5);
    check_val("wr32_beats", nbeats, 32);
    check_val("wr32_last", last_k, 36);
    check_val("wr32_done", done_k, 38);

    run_cmd(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 12'd32, 2'b00, 0);
    check_val("rd32_first", first_k, 5);
    check_val("rd32_beats", nbeats, 32);
    check_val("rd32_done", done_k, 38);
    for (int i = 0; i < 32; i++) exp_v[i] = 16'(i);
    check_read("rd32", 32);

    // wrapped write at 0x1C lands on 0x1C..0x1F then 0x00..0x03
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h0100 + 16'(i);
    run_cmd(1'b1, 1'b1, 2'b00, 1'b0, 32'h1C, 12'd8, 2'b00, 0);
    check_val("wrapw_beats", nbeats, 8);
    run_cmd(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 12'd32, 2'b00, 0);
    for (int i = 0; i < 32; i++) exp_v[i] = 16'(i);
    for (int i = 0; i < 4; i++) exp_v[i] = 16'h0104 + 16'(i);
    for (int i = 0; i < 4; i++) exp_v[28 + i] = 16'h0100 + 16'(i);
    check_read("wrap_rd", 32);

    // linear write at 0x1C lands on 0x1C..0x23
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h0200 + 16'(i);
    run_cmd(1'b1, 1'b1, 2'b00, 1'b1, 32'h1C, 12'd8, 2'b00, 0);
    run_cmd(1'b0, 1'b1, 2'b00, 1'b0, 32'h1C, 12'd8, 2'b00, 0);
    for (int i = 0; i < 4; i++) exp_v[i] = 16'h0200 + 16'(i);
    for (int i = 0; i < 4; i++) exp_v[4 + i] = 16'h0104 + 16'(i);
    check_read("wrap_rd2", 8);
    run_cmd(1'b0, 1'b1, 2'b00, 1'b1, 32'h20, 12'd4, 2'b00, 0);
    for (int i = 0; i < 4; i++) exp_v[i] = 16'h0204 + 16'(i);
    check_read("lin_rd", 4);

    // byte mask and 8-bit read
    wbuf[0] = 16'hABCD;
    run_cmd(1'b1, 1'b1, 2'b00, 1'b1, 32'h40, 12'd1, 2'b00, 0);
    check_val("len1_first", first_k, 5);
    check_val("len1_done", done_k, 7);
    wbuf[0] = 16'h1234;
    run_cmd(1'b1, 1'b1, 2'b10, 1'b1, 32'h40, 12'd1, 2'b00, 0);
    run_cmd(1'b0, 1'b1, 2'b00, 1'b1, 32'h40, 12'd1, 2'b00, 0);
    check_val("mask_rd16", rbuf[0], 16'hAB34);
    run_cmd(1'b0, 1'b0, 2'b00, 1'b1, 32'h40, 12'd1, 2'b00, 0);
    check_val("mask_rd8", rbuf[0], 16'h0034);
    check_val("hold_data_out", data_out, 16'h0034);

    // register command: no beats, exe held high while busy is not queued
    run_cmd(1'b0, 1'b1, 2'b00, 1'b1, 32'h0, 12'd32, 2'b01, 3);
    check_val("regcmd_beats", nbeats, 0);
    check_val("regcmd_done", done_k, 7);
    begin
      int low_cnt;
      low_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge sys_clk);
        if (!psram_done || psram_wr_valid || psram_rd_valid) low_cnt++;
      end
      check_val("no_queued_cmd", low_cnt, 0);
    end

    // reset on the 10th beat of a 32-beat write
    for (int i = 0; i < 32; i++) wbuf[i] = 16'h5A00 + 16'(i);
    rst_beat = 10;
    run_cmd(1'b1, 1'b1, 2'b00, 1'b1, 32'h80, 12'd32, 2'b00, 0);
    rst_beat = -1;
    check_val("rst_aborted", aborted, 1);
    check_val("rst_beats_seen", nbeats, 10);
    repeat (2) @(negedge sys_clk);
    release_and_check_init();
    run_cmd(1'b0, 1'b1, 2'b00, 1'b1, 32'h80, 12'd9, 2'b00, 0);
    check_val("post_rst_beats", nbeats, 9);
    check_val("post_rst_done", done_k, 15);
    for (int i = 0; i < 9; i++) exp_v[i] = 16'h5A00 + 16'(i);
    check_read("post_rst_rd", 9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1);
  end
endmodule
